inst_decode: RTL
================

Name: inst_decode

Overview:
- ID stage of the 5-stage ARM pipeline. Sits directly downstream of instruction fetch and consumes instruction_ID/pc_ID.
- Decodes the instruction and reads a 15x32 register file; WB writes back into that file.
- Evaluates the condition field against NZCV and detects RAW hazards, driving hazard back to fetch.
- Registers all results into the ID/EX pipeline register. That register's branch bit is B_EXE, which feeds fetch and flushes this stage.

Parameters:
- DW, 32, datapath width.
- FWD_EN, 0: 0 = stall on any RAW match against the EXE or MEM destination; 1 = stall only on a load-use match in EXE.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- instruction_ID  in  32  instruction from the IF/ID register.
- pc_ID  in  32  pc+4 from the IF/ID register.
- status  in  4  {N,Z,C,V} from the status register.
- WB_EN_WB  in  1  writeback enable.
- Dest_WB  in  4  writeback register index.
- Value_WB  in  DW  writeback data.
- WB_EN_MEM  in  1  MEM-stage writeback enable, for hazard detection.
- Dest_MEM  in  4  MEM-stage destination register.
- hazard  out  1  combinational stall request to fetch and this stage.
- WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, S_EXE, B_EXE  out  1 each  registered controls.
- EXE_CMD_EXE  out  4  registered ALU command.
- Val_Rn_EXE, Val_Rm_EXE, pc_EXE  out  DW each  registered operand values and pc+4.
- Dest_EXE  out  4  registered destination register.
- imm_EXE  out  1  registered I bit.
- shift_operand_EXE  out  12  registered shifter operand.
- signed_imm_24_EXE  out  24  registered branch offset.
- C_EXE  out  1  registered carry flag, for ADC/SBC.

Behaviour:
- Reset (rst==0 at posedge): all ID/EX outputs are cleared to 0 and R0..R14 are cleared to 0. hazard still evaluates combinationally from its inputs.
- Instruction fields:
  - cond [31:28], mode [27:26], I [25], opcode [24:21], S [20].
  - Rn [19:16], Rd [15:12], Rm [3:0], shifter [11:0], imm24 [23:0].
- Decode for mode 00 (data processing), giving EXE_CMD:
  - MOV 1101->0001, MVN 1111->1001.
  - ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101.
  - AND 0000->0110, ORR 1100->0111, EOR 0001->1000.
  - CMP 1010->0100, TST 1000->0110.
  - WB_EN=1 for all of these except CMP and TST.
  - Undefined opcodes decode as a NOP (all controls 0).
- Decode for mode 01 (memory):
  - S=1 is LDR: MEM_R_EN=1, WB_EN=1, EXE_CMD=0010.
  - S=0 is STR: MEM_W_EN=1, EXE_CMD=0010.
- Decode for mode 10: B=1, all other controls 0.
- Mode 11: NOP.
- Condition codes:
  - EQ 0000, NE 0001, CS 0010, CC 0011, MI 0100, PL 0101, VS 0110, VC 0111.
  - HI 1000 (C&~Z), LS 1001, GE 1010 (N==V), LT 1011, GT 1100 (~Z&N==V), LE 1101, AL 1110.
  - 1111 evaluates false.
- Register file:
  - Write on posedge when WB_EN_WB && rst && Dest_WB!=15.
  - Reads are combinational. A read of the same index being written in the same cycle returns Value_WB (write-through bypass).
  - Index 15 reads return pc_ID.
- Operand sources:
  - Val_Rn = RF[Rn].
  - Val_Rm = RF[MEM_W_EN ? Rd : Rm].
- Hazard detection:
  - src1 = Rn. src2 = MEM_W_EN ? Rd : Rm.
  - two_src = ~I | MEM_W_EN.
  - src1 is checked only for data-processing ops other than MOV/MVN, and for memory ops. Branches and NOPs never cause hazard.
  - FWD_EN=0: hazard = (WB_EN_EXE && Dest_EXE==src1) || (WB_EN_MEM && Dest_MEM==src1), plus the same terms on src2 gated by two_src.
  - FWD_EN=1: only the EXE terms count, and they are gated additionally by MEM_R_EN_EXE.
- Control-zeroing (bubble): when hazard=1 or cond fails, WB_EN, MEM_R_EN, MEM_W_EN, B and S are forced to 0 before registering. Data fields still register normally.
- Flush (B_EXE==1 at posedge):
  - The ID/EX register loads all zeros. The current ID instruction is on the wrong path.
  - Flush has priority over hazard-bubble and over normal load.
  - B_EXE self-clears the following cycle.
- Latency: one cycle from ID inputs to _EXE outputs. Register file writes are visible to ID reads in the same cycle via the bypass.
- C_EXE registers status[1] every cycle (0 under reset and flush).

Test Plan:
- Reset: rst=0 for 2 cycles -> all _EXE outputs 0, Val_Rn of R3 reads 0. Release, then write R3=0x55 via WB -> next cycle ADD R1,R3,#1 gives Val_Rn_EXE=0x55, EXE_CMD_EXE=0010, WB_EN_EXE=1.
- Bypass: WB writes R2=0xDEADBEEF in the same cycle ID reads R2 -> Val_Rn_EXE=0xDEADBEEF.
- Condition: status=0100 (Z=1) with ADDNE -> WB_EN_EXE=0. Same status with ADDEQ -> WB_EN_EXE=1.
- Hazard, FWD_EN=0: the instruction before writes R4, then SUB R5,R4,R6 -> hazard=1 for 2 cycles and a bubble (controls 0).
- Hazard, FWD_EN=1: same sequence -> no hazard. LDR R4 followed by ADD R5,R4,R4 -> hazard=1 for exactly 1 cycle.
- Branch flush: B (AL) with imm24=0x000010 -> B_EXE=1, signed_imm_24_EXE=0x000010. Next cycle all _EXE outputs 0 even with a valid ADD in ID.

Source files
------------

// File: rtl/inst_decode.sv
`default_nettype none
// ============================================================================
// Module   : inst_decode
// Purpose  : ARM ID stage - decode, condition check, 15x32 register file,
//            RAW hazard detection and the ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module inst_decode #(
  parameter int DW     = 32,
  parameter int FWD_EN = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instruction_ID,
  input  logic [31:0]   pc_ID,
  input  logic [3:0]    status,
  input  logic          WB_EN_WB,
  input  logic [3:0]    Dest_WB,
  input  logic [DW-1:0] Value_WB,
  input  logic          WB_EN_MEM,
  input  logic [3:0]    Dest_MEM,
  output logic          hazard,
  output logic          WB_EN_EXE,
  output logic          MEM_R_EN_EXE,
  output logic          MEM_W_EN_EXE,
  output logic          S_EXE,
  output logic          B_EXE,
  output logic [3:0]    EXE_CMD_EXE,
  output logic [DW-1:0] Val_Rn_EXE,
  output logic [DW-1:0] Val_Rm_EXE,
  output logic [DW-1:0] pc_EXE,
  output logic [3:0]    Dest_EXE,
  output logic          imm_EXE,
  output logic [11:0]   shift_operand_EXE,
  output logic [23:0]   signed_imm_24_EXE,
  output logic          C_EXE
);

  localparam logic [1:0] c_mode_dp  = 2'b00;
  localparam logic [1:0] c_mode_mem = 2'b01;
  localparam logic [1:0] c_mode_br  = 2'b10;

  localparam logic [3:0] c_op_mov = 4'b1101;
  localparam logic [3:0] c_op_mvn = 4'b1111;
  localparam logic [3:0] c_op_add = 4'b0100;
  localparam logic [3:0] c_op_adc = 4'b0101;
  localparam logic [3:0] c_op_sub = 4'b0010;
  localparam logic [3:0] c_op_sbc = 4'b0110;
  localparam logic [3:0] c_op_and = 4'b0000;
  localparam logic [3:0] c_op_orr = 4'b1100;
  localparam logic [3:0] c_op_eor = 4'b0001;
  localparam logic [3:0] c_op_cmp = 4'b1010;
  localparam logic [3:0] c_op_tst = 4'b1000;

  logic [3:0]  w_cond;
  logic [1:0]  w_mode;
  logic        w_i;
  logic [3:0]  w_opcode;
  logic        w_s;
  logic [3:0]  w_rn;
  logic [3:0]  w_rd;
  logic [3:0]  w_rm;

  assign w_cond   = instruction_ID[31:28];
  assign w_mode   = instruction_ID[27:26];
  assign w_i      = instruction_ID[25];
  assign w_opcode = instruction_ID[24:21];
  assign w_s      = instruction_ID[20];
  assign w_rn     = instruction_ID[19:16];
  assign w_rd     = instruction_ID[15:12];
  assign w_rm     = instruction_ID[3:0];

  logic [3:0]  w_exe_cmd;
  logic        w_wb_en;
  logic        w_mem_r_en;
  logic        w_mem_w_en;
  logic        w_b;
  logic        w_s_ctl;
  logic        w_op_valid;
  logic        w_uses_rn;

  always_comb begin
    w_exe_cmd  = 4'b0000;
    w_wb_en    = 1'b0;
    w_mem_r_en = 1'b0;
    w_mem_w_en = 1'b0;
    w_b        = 1'b0;
    w_s_ctl    = 1'b0;
    w_op_valid = 1'b0;
    w_uses_rn  = 1'b0;
    case (w_mode)
      c_mode_dp: begin
        w_op_valid = 1'b1;
        w_wb_en    = 1'b1;
        w_uses_rn  = 1'b1;
        case (w_opcode)
          c_op_mov: begin w_exe_cmd = 4'b0001; w_uses_rn = 1'b0; end
          c_op_mvn: begin w_exe_cmd = 4'b1001; w_uses_rn = 1'b0; end
          c_op_add: w_exe_cmd = 4'b0010;
          c_op_adc: w_exe_cmd = 4'b0011;
          c_op_sub: w_exe_cmd = 4'b0100;
          c_op_sbc: w_exe_cmd = 4'b0101;
          c_op_and: w_exe_cmd = 4'b0110;
          c_op_orr: w_exe_cmd = 4'b0111;
          c_op_eor: w_exe_cmd = 4'b1000;
          c_op_cmp: begin w_exe_cmd = 4'b0100; w_wb_en = 1'b0; end
          c_op_tst: begin w_exe_cmd = 4'b0110; w_wb_en = 1'b0; end
          default: begin
            w_op_valid = 1'b0;
            w_wb_en    = 1'b0;
            w_uses_rn  = 1'b0;
          end
        endcase
        w_s_ctl = w_s & w_op_valid;
      end
      c_mode_mem: begin
        w_op_valid = 1'b1;
        w_uses_rn  = 1'b1;
        w_exe_cmd  = 4'b0010;
        w_mem_r_en = w_s;
        w_wb_en    = w_s;
        w_mem_w_en = ~w_s;
      end
      c_mode_br: w_b = 1'b1;
      default: ;
    endcase
  end

  logic w_n, w_z, w_c, w_v;
  logic w_cond_ok;

  assign {w_n, w_z, w_c, w_v} = status;

  always_comb begin
    case (w_cond)
      4'h0:    w_cond_ok = w_z;
      4'h1:    w_cond_ok = ~w_z;
      4'h2:    w_cond_ok = w_c;
      4'h3:    w_cond_ok = ~w_c;
      4'h4:    w_cond_ok = w_n;
      4'h5:    w_cond_ok = ~w_n;
      4'h6:    w_cond_ok = w_v;
      4'h7:    w_cond_ok = ~w_v;
      4'h8:    w_cond_ok = w_c & ~w_z;
      4'h9:    w_cond_ok = ~w_c | w_z;
      4'hA:    w_cond_ok = (w_n == w_v);
      4'hB:    w_cond_ok = (w_n != w_v);
      4'hC:    w_cond_ok = ~w_z & (w_n == w_v);
      4'hD:    w_cond_ok = w_z | (w_n != w_v);
      4'hE:    w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // Register file: R15 is not stored, reads of index 15 return pc_ID.
  logic [DW-1:0] r_rf [15];
  logic          w_wr_en;
  logic [3:0]    w_src2;
  logic [DW-1:0] w_val_rn;
  logic [DW-1:0] w_val_rm;

  assign w_wr_en = WB_EN_WB && rst && (Dest_WB != 4'd15);
  assign w_src2  = w_mem_w_en ? w_rd : w_rm;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 15; k++) r_rf[k] <= '0;
    end else if (w_wr_en) begin
      r_rf[Dest_WB] <= Value_WB;
    end
  end

  always_comb begin
    if (w_rn == 4'd15)                     w_val_rn = DW'(pc_ID);
    else if (w_wr_en && (Dest_WB == w_rn)) w_val_rn = Value_WB;
    else                                   w_val_rn = r_rf[w_rn];
  end

  always_comb begin
    if (w_src2 == 4'd15)                     w_val_rm = DW'(pc_ID);
    else if (w_wr_en && (Dest_WB == w_src2)) w_val_rm = Value_WB;
    else                                     w_val_rm = r_rf[w_src2];
  end

  logic          r_wb_en, r_mem_r_en, r_mem_w_en, r_s, r_b, r_imm, r_c;
  logic [3:0]    r_exe_cmd, r_dest;
  logic [DW-1:0] r_val_rn, r_val_rm, r_pc;
  logic [11:0]   r_shift_operand;
  logic [23:0]   r_signed_imm_24;

  logic w_two_src, w_chk1, w_chk2, w_exe_hit, w_mem_hit, w_hazard, w_kill;

  assign w_two_src = ~w_i | w_mem_w_en;
  assign w_chk1    = w_uses_rn;
  assign w_chk2    = w_op_valid & w_two_src;
  assign w_exe_hit = r_wb_en &
                     ((w_chk1 & (r_dest == w_rn)) | (w_chk2 & (r_dest == w_src2)));
  assign w_mem_hit = WB_EN_MEM &
                     ((w_chk1 & (Dest_MEM == w_rn)) | (w_chk2 & (Dest_MEM == w_src2)));
  // With forwarding only a load result still in EXE cannot be bypassed.
  assign w_hazard  = (FWD_EN != 0) ? (w_exe_hit & r_mem_r_en) : (w_exe_hit | w_mem_hit);
  assign w_kill    = w_hazard | ~w_cond_ok;
  assign hazard    = w_hazard;

  always_ff @(posedge clk) begin
    if (!rst || r_b) begin
      r_wb_en         <= 1'b0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_s             <= 1'b0;
      r_b             <= 1'b0;
      r_exe_cmd       <= 4'b0000;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_pc            <= '0;
      r_dest          <= 4'b0000;
      r_imm           <= 1'b0;
      r_shift_operand <= 12'h000;
      r_signed_imm_24 <= 24'h000000;
      r_c             <= 1'b0;
    end else begin
      r_wb_en         <= w_wb_en & ~w_kill;
      r_mem_r_en      <= w_mem_r_en & ~w_kill;
      r_mem_w_en      <= w_mem_w_en & ~w_kill;
      r_s             <= w_s_ctl & ~w_kill;
      r_b             <= w_b & ~w_kill;
      r_exe_cmd       <= w_exe_cmd;
      r_val_rn        <= w_val_rn;
      r_val_rm        <= w_val_rm;
      r_pc            <= DW'(pc_ID);
      r_dest          <= w_rd;
      r_imm           <= w_i;
      r_shift_operand <= instruction_ID[11:0];
      r_signed_imm_24 <= instruction_ID[23:0];
      r_c             <= status[1];
    end
  end

  assign WB_EN_EXE         = r_wb_en;
  assign MEM_R_EN_EXE      = r_mem_r_en;
  assign MEM_W_EN_EXE      = r_mem_w_en;
  assign S_EXE             = r_s;
  assign B_EXE             = r_b;
  assign EXE_CMD_EXE       = r_exe_cmd;
  assign Val_Rn_EXE        = r_val_rn;
  assign Val_Rm_EXE        = r_val_rm;
  assign pc_EXE            = r_pc;
  assign Dest_EXE          = r_dest;
  assign imm_EXE           = r_imm;
  assign shift_operand_EXE = r_shift_operand;
  assign signed_imm_24_EXE = r_signed_imm_24;
  assign C_EXE             = r_c;

endmodule
`default_nettype wire
